// File: rtl/stream_mod_pkg.sv
// Shared definitions for the serial divisibility checker: divisor limits,
// remainder-width helper and the per-lane state record.
package stream_mod_pkg;

   localparam int MAX_DIVISOR = 255;

   function automatic int rem_w(input int divisor);
      return $clog2(divisor);
   endfunction

   localparam int MAX_REM_W = rem_w(MAX_DIVISOR);

   // Sized for the largest legal divisor; a lane only ever writes the low
   // rem_w(DIVISOR) bits, so the upper bits stay zero and synthesise away.
   typedef struct packed {
      logic [MAX_REM_W-1:0] rem;
      logic                 seen;
   } lane_state_t;

endpackage : stream_mod_pkg

// File: rtl/stream_mod_checker_mod_lane.sv
// One channel of the divisibility checker: running remainder, seen flag and
// the next-remainder modulo. rem_out exists only with STREAM_MOD_REM_OUT_EN.
module mod_lane
   import stream_mod_pkg::*;
#(
   parameter  int BEAT_W  = 1,
   parameter  int DIVISOR = 3,
   localparam int REM_W   = rem_w(DIVISOR)
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              din_valid,
   input  logic [BEAT_W-1:0] din,
   input  logic              clear,
   output logic              dout,
   output logic              dout_valid
`ifdef STREAM_MOD_REM_OUT_EN
   ,
   output logic [REM_W-1:0]  rem_out
`endif
);

   // REM_W+BEAT_W always holds (DIVISOR-1)*2^BEAT_W + (2^BEAT_W-1), and also
   // DIVISOR itself, so neither the shift nor the divisor constant overflows.
   localparam int WIDE_W = REM_W + BEAT_W;

   lane_state_t       r_state;
   logic              r_dout_valid;

   lane_state_t       w_state_next;
   logic [REM_W-1:0]  w_rem_base;
   logic [WIDE_W-1:0] w_wide;
   logic [WIDE_W-1:0] w_mod;
   logic [REM_W-1:0]  w_rem_next;

   // NOTE: every signal written here is given a default first, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      w_state_next = r_state;
      // A clear that coincides with a beat makes that beat the first digit.
      w_rem_base   = clear ? '0 : r_state.rem[REM_W-1:0];
      w_wide       = {w_rem_base, din};
      w_mod        = w_wide % WIDE_W'(DIVISOR);
      w_rem_next   = REM_W'(w_mod);
      if (din_valid) begin
         w_state_next.rem  = MAX_REM_W'(w_rem_next);
         w_state_next.seen = 1'b1;
      end else if (clear) begin
         w_state_next.rem  = '0;
         w_state_next.seen = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; the async reset clears them without waiting for clk.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state      <= '0;
         r_dout_valid <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_dout_valid <= din_valid;
      end
   end

   // The zero held after reset or a bare clear is not a number, hence seen.
   assign dout       = r_state.seen & (r_state.rem == '0);
   assign dout_valid = r_dout_valid;

`ifdef STREAM_MOD_REM_OUT_EN
   assign rem_out = r_state.rem[REM_W-1:0];
`endif

endmodule : mod_lane

// File: rtl/stream_mod_checker.sv
// Multi-channel MSB-first serial divisibility checker; one mod_lane per channel.
// Optional remainder port enabled by defining STREAM_MOD_REM_OUT_EN.
module stream_mod_checker
   import stream_mod_pkg::*;
#(
   parameter  int NUM_CH  = 1,
   parameter  int BEAT_W  = 1,
   parameter  int DIVISOR = 3
`ifdef STREAM_MOD_REM_OUT_EN
   ,
   localparam int REM_W   = rem_w(DIVISOR)
`endif
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic [NUM_CH-1:0]        din_valid,
   input  logic [NUM_CH*BEAT_W-1:0] din,
   input  logic [NUM_CH-1:0]        clear,
   output logic [NUM_CH-1:0]        dout,
   output logic [NUM_CH-1:0]        dout_valid
`ifdef STREAM_MOD_REM_OUT_EN
   ,
   output logic [NUM_CH*REM_W-1:0]  rem_out
`endif
);

   if (DIVISOR < 2 || DIVISOR > MAX_DIVISOR || BEAT_W < 1) begin : g_bad_params
      $fatal(1, "stream_mod_checker: DIVISOR must be 2..255 and BEAT_W >= 1");
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
      mod_lane #(
         .BEAT_W  (BEAT_W),
         .DIVISOR (DIVISOR)
      ) u_lane (
         .clk        (clk),
         .resetn     (resetn),
         .din_valid  (din_valid[c]),
         .din        (din[c*BEAT_W +: BEAT_W]),
         .clear      (clear[c]),
         .dout       (dout[c]),
         .dout_valid (dout_valid[c])
`ifdef STREAM_MOD_REM_OUT_EN
         ,
         .rem_out    (rem_out[c*REM_W +: REM_W])
`endif
      );
   end

endmodule : stream_mod_checker
